inst_prefetch_unit: RTL and testbench

INST_PREFETCH_UNIT -- requirements
Module: inst_prefetch_unit

---
 rtl/inst_prefetch_unit_pkg.sv | 19 +
 rtl/inst_prefetch_unit_fetch_fifo.sv | 60 ++++++
 rtl/inst_prefetch_unit.sv | 101 ++++++++++
 tb/tb_inst_prefetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: data width, the NOP
// encoding driven when no instruction is available, and the queue entry type.
package inst_prefetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One queued instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the two low address bits so the result is word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/inst_prefetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched instructions. The head entry is read
// straight from registered storage, so a push is visible one cycle later.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous flush; wins over push/pop
//   push, push_data write one entry (ignored when full without a pop)
//   pop             remove the head entry (ignored when empty)
//   head            current head entry (don't-care when count == 0)
//   count           current occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Entry storage needs no reset: occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches to instruction
// memory, queues returned words with their PCs, and presents the head to the
// IF/ID stage. A redirect flushes the queue and drops every in-flight response.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   redirect, redirect_pc        taken branch/jump and its target
//   imem_req/addr/gnt            fetch request handshake
//   imem_rvalid/rdata            in-order fetch responses
//   deq_ready                    downstream accepts the head instruction
//   inst_valid, inst, inst_pc    head instruction (NOP / 0 when not valid)
module inst_prefetch_unit
  import inst_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard_cnt;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            accept;
  logic            resp_keep;
  logic            pop;

  // Every outstanding request holds a queue slot, so the queue can never overflow
  assign imem_req  = !rst && !redirect && (outstanding < OW'(MAX_OUT)) &&
                     ((32'(fifo_count) + 32'(outstanding)) < DEPTH);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_gnt;

  assign resp_keep  = imem_rvalid && (discard_cnt == '0) && !redirect;
  assign push_entry = '{pc: resp_pc, inst: imem_rdata};

  assign inst_valid = (fifo_count != '0) && !redirect;
  assign inst       = inst_valid ? fifo_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_head.pc : '0;
  assign pop        = inst_valid & deq_ready;

  // Fetch/response PCs and in-flight bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      if (accept && !imem_rvalid)      outstanding <= outstanding + OW'(1);
      else if (!accept && imem_rvalid) outstanding <= outstanding - OW'(1);

      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        // Whatever is still in flight after this cycle is stale
        discard_cnt <= outstanding - OW'(imem_rvalid && (outstanding != '0));
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid) begin
          if (discard_cnt != '0) discard_cnt <= discard_cnt - OW'(1);
          else                   resp_pc     <= resp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit with a small in-order memory model
// whose response data is the bitwise inverse of the request address.
module tb_inst_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          lat;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_pc;

  inst_prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .deq_ready   (deq_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record a handshake, take the edge, present any due response
  task automatic tick();
    #1;
    if (!rst && imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
    @(posedge clk);
    #1;
    cyc++;
    if (rst) pend.delete();
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!inst_valid && n < 30);
    check("wait_valid", 32'(inst_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0000_0000);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'h0000_0013);
    check({tag, "_pc"}, inst_pc, 32'h0000_0000);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; deq_ready = 1'b1;
    lat = 1; cyc = 0; n_checks = 0; n_fail = 0; exp_pc = '0;

    // Reset values
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    check("rst_hold_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0000_0000);

    // Zero-wait streaming: 2-cycle fill then one instruction per cycle
    tick();
    check("fill_valid0", 32'(inst_valid), 32'd0);
    check("fill_addr", imem_addr, 32'h0000_0004);
    tick();
    check("fill_valid1", 32'(inst_valid), 32'd1);
    check("fill_pc", inst_pc, 32'h0000_0000);
    check("fill_inst", inst, 32'hFFFF_FFFF);
    exp_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_pc += 32'd4;
      check("stream_valid", 32'(inst_valid), 32'd1);
      check("stream_pc", inst_pc, exp_pc);
      check("stream_inst", inst, ~exp_pc);
    end

    // Stall: queue saturates, requests stop, head held
    deq_ready = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    check("stall_pc", inst_pc, exp_pc);
    deq_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_pc += 32'd4;
      check("resume_valid", 32'(inst_valid), 32'd1);
      check("resume_pc", inst_pc, exp_pc);
      check("resume_inst", inst, ~exp_pc);
    end

    // Latency-3 memory, two in flight, redirect to an unaligned target
    lat = 3;
    do_reset();
    tick();
    tick();
    check("l3_max_out_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("l3_redir_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("l3_redir_addr", imem_addr, 32'h0000_0100);
    wait_valid();
    check("l3_pc0", inst_pc, 32'h0000_0100);
    check("l3_inst0", inst, ~32'h0000_0100);
    wait_valid();
    check("l3_pc1", inst_pc, 32'h0000_0104);
    check("l3_inst1", inst, ~32'h0000_0104);

    // Redirect coinciding with a response and a dequeue; one more still in flight
    lat = 2; deq_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check("co_pre_valid", 32'(inst_valid), 32'd1);
    check("co_pre_pc", inst_pc, 32'h0000_0000);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; deq_ready = 1'b1;
    #1;
    check("co_valid", 32'(inst_valid), 32'd0);
    check("co_inst", inst, 32'h0000_0013);
    check("co_pc", inst_pc, 32'h0000_0000);
    check("co_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    wait_valid();
    check("co_new_pc0", inst_pc, 32'h0000_0200);
    check("co_new_inst0", inst, ~32'h0000_0200);
    wait_valid();
    check("co_new_pc1", inst_pc, 32'h0000_0204);
    check("co_new_inst1", inst, ~32'h0000_0204);

    // Idle redirect near the top of the address space, then wrap to 0
    lat = 1; deq_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    check("wrap_redir_req", 32'(imem_req), 32'd0);
    check("wrap_redir_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_idle_valid", 32'(inst_valid), 32'd0);
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr2", imem_addr, 32'h0000_0000);
    check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2", inst_pc, 32'h0000_0000);
    check("wrap_inst2", inst, 32'hFFFF_FFFF);

    // Reset mid-operation with a part-full queue and a request in flight
    lat = 3; deq_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    check("mid_pre_valid", 32'(inst_valid), 32'd1);
    check("mid_pre_pc", inst_pc, 32'h0000_0000);
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    pend.delete();
    #1;
    check_reset_outputs("mid_rst");
    tick();
    lat = 1; deq_ready = 1'b1; rst = 1'b0;
    #1;
    check("mid_restart_req", 32'(imem_req), 32'd1);
    check("mid_restart_addr", imem_addr, 32'h0000_0000);
    tick();
    tick();
    check("mid_restart_valid", 32'(inst_valid), 32'd1);
    check("mid_restart_pc", inst_pc, 32'h0000_0000);
    check("mid_restart_inst", inst, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
